jtframe_joydb9_tx: RTL and testbench

- Device-side end of the DB9 serial joystick link: the block takes the host's JOY_CLK and JOY_LOAD strobes and drives JOY_DATA.
- It emulates the external shift-register adapter, so two parallel joystick states can be serialised to a host-side DB9 reader.
- Uses: board-level adapters, and loop-back simulation of the host reader inside jtframe benches.
- JOY_CLK arrives asynchronously from the host. It is synchronised into the system clock domain, so no logic runs on JOY_CLK itself.

---
 rtl/jtframe_joydb9_tx.sv | 128 ++++++++++++
 tb/tb_jtframe_joydb9_tx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/jtframe_joydb9_tx.sv
// jtframe_joydb9_tx
// Device-side end of the DB9 serial joystick link. It emulates the external
// shift-register adapter: on the host's load strobe it snapshots two joystick
// states, then presents one line bit per host clock on joy_data.
// The host clock and load inputs are synchronised into clk, and all logic
// runs on clk.
//
// Ports:
//   clk          system clock, at least 8x the joy_clk frequency
//   rst          synchronous, active-high reset
//   joy_clk      host shift clock (asynchronous)
//   joy_load     host load strobe, active-low (asynchronous)
//   joystick1/2  player states, active-high, [5:0] = fire2 fire1 up down left right
//   joy_data     registered serial line to the host, active-low, idles at 1
//   active       high from the first load until the inactivity timeout
//   frame_strobe one-clk pulse once the last data bit of a frame is presented
module jtframe_joydb9_tx #(
    parameter int              LEAD    = 1,
    parameter int              TOW     = 16,
    parameter logic [TOW-1:0]  TIMEOUT = 16'd40000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        joy_clk,
    input  logic        joy_load,
    input  logic [15:0] joystick1,
    input  logic [15:0] joystick2,
    output logic        joy_data,
    output logic        active,
    output logic        frame_strobe
);

    localparam logic [4:0] IDX_IDLE = 5'd31;
    localparam logic [4:0] IDX_LEAD = 5'(LEAD);
    localparam logic [4:0] IDX_END  = 5'(LEAD + 12);

    logic           clk_m, clk_s, clk_q;
    logic           load_m, load_s;
    logic           rise;
    logic [4:0]     idx;
    logic [5:0]     snap1, snap2;
    logic [TOW-1:0] tcnt;
    logic           step;

    // Only the six mapped bits of each joystick word are serialised.
    logic unused_bits;
    assign unused_bits = ^{joystick1[15:6], joystick2[15:6]};

    assign rise = clk_s & ~clk_q;

    // Line value for frame position i. Each player contributes
    // fire2, fire1, right, left, down, up, inverted onto the line.
    function automatic logic map_bit(input logic [4:0] i,
                                     input logic [5:0] s1,
                                     input logic [5:0] s2);
        logic [4:0] pos;
        logic [5:0] s;
        map_bit = 1'b1;
        pos     = 5'd0;
        s       = s1;
        if (i >= IDX_LEAD && i < IDX_END) begin
            pos = i - IDX_LEAD;
            if (pos >= 5'd6) begin
                s   = s2;
                pos = pos - 5'd6;
            end
            case (pos)
                5'd0:    map_bit = ~s[5];
                5'd1:    map_bit = ~s[4];
                5'd2:    map_bit = ~s[0];
                5'd3:    map_bit = ~s[1];
                5'd4:    map_bit = ~s[2];
                5'd5:    map_bit = ~s[3];
                default: map_bit = 1'b1;
            endcase
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_m        <= 1'b1;
            clk_s        <= 1'b1;
            clk_q        <= 1'b1;
            load_m       <= 1'b1;
            load_s       <= 1'b1;
            idx          <= IDX_IDLE;
            snap1        <= 6'd0;
            snap2        <= 6'd0;
            tcnt         <= '0;
            step         <= 1'b0;
            joy_data     <= 1'b1;
            active       <= 1'b0;
            frame_strobe <= 1'b0;
        end else begin
            clk_m  <= joy_clk;
            clk_s  <= clk_m;
            clk_q  <= clk_s;
            load_m <= joy_load;
            load_s <= load_m;

            joy_data <= map_bit(idx, snap1, snap2);

            // step marks an increment of idx, so the strobe fires only when
            // idx advances onto the end position, never after a reload.
            step         <= 1'b0;
            frame_strobe <= step && (idx == IDX_END);

            if (rise) begin
                tcnt <= '0;
                if (!load_s) begin
                    snap1  <= joystick1[5:0];
                    snap2  <= joystick2[5:0];
                    idx    <= 5'd0;
                    active <= 1'b1;
                end else if (idx != IDX_IDLE) begin
                    idx  <= idx + 5'd1;
                    step <= 1'b1;
                end
            end else if (tcnt == TIMEOUT) begin
                active <= 1'b0;
                idx    <= IDX_IDLE;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jtframe_joydb9_tx.sv
// Testbench for jtframe_joydb9_tx: a host model drives joy_clk = clk/128 and
// joy_load; every host rising edge has its expected line value queued by the
// stimulus and checked by an independent monitor at the host sample point.
`timescale 1ns/1ps
module tb_jtframe_joydb9_tx;

    localparam int             LEAD    = 1;
    localparam logic [15:0]    TIMEOUT = 16'd2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        joy_clk = 1'b0;
    logic        joy_load = 1'b1;
    logic [15:0] joystick1 = 16'h0000;
    logic [15:0] joystick2 = 16'h0000;
    logic        joy_data, active, frame_strobe;

    int n_cmp = 0;
    int n_bad = 0;
    int n_strobe = 0;
    int n_samp = 0;
    logic act4;
    logic exp_q[$];

    always #5 clk = ~clk;

    jtframe_joydb9_tx #(.LEAD(LEAD), .TOW(16), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .joy_clk(joy_clk), .joy_load(joy_load),
        .joystick1(joystick1), .joystick2(joystick2),
        .joy_data(joy_data), .active(active), .frame_strobe(frame_strobe)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected line value at frame position i (LEAD = 1).
    function automatic logic line_bit(input int i, input logic [5:0] s1, input logic [5:0] s2);
        logic [5:0] s;
        int k;
        if (i < LEAD || i > LEAD + 11) return 1'b1;
        k = (i - LEAD) % 6;
        s = (i < LEAD + 6) ? s1 : s2;
        case (k)
            0:       return ~s[5];
            1:       return ~s[4];
            2:       return ~s[0];
            3:       return ~s[1];
            4:       return ~s[2];
            default: return ~s[3];
        endcase
    endfunction

    // One host clock period: low half then high half, 64 clk each.
    task automatic period(input logic ld_n, input logic exp, input logic do_rst);
        exp_q.push_back(exp);
        joy_load = ld_n;
        if (do_rst) begin
            wclk(10);
            rst = 1'b1;
            wclk(1);
            rst = 1'b0;
            check("rst_line_high", joy_data, 1);
            check("rst_active_low", active, 0);
            wclk(53);
        end else begin
            wclk(64);
        end
        joy_clk = 1'b1;
        wclk(4);
        act4 = active;
        wclk(60);
        joy_clk = 1'b0;
    endtask

    // Periods lo..hi of a frame; period 0 is the load period.
    task automatic frame_range(input logic [5:0] s1, input logic [5:0] s2, input int lo, input int hi);
        for (int p = lo; p <= hi; p++)
            period((p != 0), (p == 0) ? 1'b1 : line_bit(p - 1, s1, s2), 1'b0);
    endtask

    // Monitor: host samples joy_data on its rising edge.
    always @(posedge joy_clk) begin
        n_samp++;
        if (exp_q.size() == 0) check("queue_underflow", 1, 0);
        else check($sformatf("host_sample_%0d", n_samp), joy_data, exp_q.pop_front());
    end

    always @(negedge clk) if (frame_strobe) n_strobe++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nbad_idle;
        int s0;
        wclk(5);
        check("reset_joy_data", joy_data, 1);
        check("reset_active", active, 0);
        check("reset_strobe", frame_strobe, 0);
        rst = 1'b0;
        nbad_idle = 0;
        for (int i = 0; i < 1000; i++) begin
            wclk(1);
            if (joy_data !== 1'b1 || active !== 1'b0 || frame_strobe !== 1'b0) nbad_idle++;
        end
        check("reset_idle_bad_cycles", nbad_idle, 0);

        // Full frames: fire1+right / fire2+down.
        joystick1 = 16'h0011;
        joystick2 = 16'h0024;
        s0 = n_strobe;
        frame_range(6'h11, 6'h24, 0, 25);
        check("frame1_active", active, 1);
        check("frame1_strobes", n_strobe - s0, 1);
        s0 = n_strobe;
        frame_range(6'h11, 6'h24, 0, 25);
        check("frame2_strobes", n_strobe - s0, 1);

        // Snapshot: joystick change mid-frame waits for the next load.
        joystick1 = 16'h0000;
        frame_range(6'h00, 6'h24, 0, 4);
        joystick1 = 16'h003F;
        frame_range(6'h00, 6'h24, 5, 25);
        frame_range(6'h3F, 6'h24, 0, 25);

        // Mid-frame load at period 7 with a new joystick value.
        joystick1 = 16'h0011;
        s0 = n_strobe;
        frame_range(6'h11, 6'h24, 0, 6);
        joystick1 = 16'h002A;
        period(1'b0, line_bit(6, 6'h11, 6'h24), 1'b0);
        frame_range(6'h2A, 6'h24, 1, 25);
        check("midload_strobes", n_strobe - s0, 1);

        // Timeout with the line held low mid-frame.
        joystick1 = 16'h003F;
        joystick2 = 16'h0000;
        s0 = n_strobe;
        frame_range(6'h3F, 6'h00, 0, 4);
        wclk(int'(TIMEOUT) - 300);
        check("pre_timeout_line", joy_data, 0);
        check("pre_timeout_active", active, 1);
        wclk(400);
        check("timeout_active", active, 0);
        check("timeout_line", joy_data, 1);
        period(1'b1, 1'b1, 1'b0);
        check("no_wake_without_load", act4, 0);
        period(1'b1, 1'b1, 1'b0);
        period(1'b0, 1'b1, 1'b0);
        check("wake_within_4clk", act4, 1);
        frame_range(6'h3F, 6'h00, 1, 25);
        check("timeout_strobes", n_strobe - s0, 1);

        // Reset mid-frame at period 9.
        joystick2 = 16'h003F;
        s0 = n_strobe;
        frame_range(6'h3F, 6'h3F, 0, 8);
        period(1'b1, 1'b1, 1'b1);
        for (int p = 10; p <= 25; p++) period(1'b1, 1'b1, 1'b0);
        check("rst_frame_active", active, 0);
        frame_range(6'h3F, 6'h3F, 0, 25);
        check("post_rst_active", active, 1);
        check("rst_strobes", n_strobe - s0, 1);

        wclk(10);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
